sram_stream_reader: RTL and testbench

Read-port master for the team's generic double-port SRAM macro. It accepts a (start address, row count) command and drives the SRAM read port (REB/AB). It absorbs the macro's 1-cycle registered read latency and emits the rows as a valid/ready stream with a last flag. It sits between accelerator datapaths and the SRAM read port, while the write port stays with the existing writer logic.

---
 rtl/sram_stream_pkg.sv | 12 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/sram_stream_reader.sv | 148 ++++++++++++++
 tb/tb_sram_stream_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_pkg.sv
// Shared types and constants for the SRAM stream reader and related read-port masters.
package sram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FifoDepth = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CntW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count == CntW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// Read-port master: turns an (address, row count) command into SRAM reads and a
// valid/ready row stream with a last flag, hiding the macro's one-cycle read latency.
module sram_stream_reader
    import sram_stream_pkg::*;
#(
    parameter  int WIDTH        = 128,
    parameter  int NUM_ROWS     = 4096,
    localparam int AddressWidth = $clog2(NUM_ROWS),
    localparam int CountWidth   = $clog2(NUM_ROWS + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [AddressWidth-1:0] start_addr,
    input  logic [CountWidth-1:0]   start_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    REB,
    output logic [AddressWidth-1:0] AB,
    input  logic [WIDTH-1:0]        Q,
    output state_e                  dbg_state
);

    // Handshake rule for both streams: a transfer happens on a rising CLK edge where
    // valid and ready are both high; out_data/out_last hold while valid is high and ready low.

    localparam int FifoCountW = $clog2(FifoDepth + 1);
    localparam logic [AddressWidth-1:0] LastRow = AddressWidth'(NUM_ROWS - 1);

    state_e                  state;
    state_e                  state_next;
    logic [AddressWidth-1:0] addr_q;
    logic [CountWidth-1:0]   left_q;
    logic [AddressWidth-1:0] ab_q;
    logic                    reb_q;
    logic                    reb_last_q;
    logic                    pend_q;
    logic                    pend_last_q;

    logic                    issue;
    logic                    issue_last;
    logic [AddressWidth-1:0] issue_addr;
    logic [CountWidth-1:0]   issue_left;

    logic [FifoCountW-1:0]   fifo_count;
    logic [FifoCountW:0]     occupancy;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    pop;
    logic [WIDTH:0]          fifo_rdata;

    // Rows already committed: buffered, returning on Q now, or being read this cycle.
    assign occupancy = {1'b0, fifo_count}
                     + (FifoCountW + 1)'(reb_q)
                     + (FifoCountW + 1)'(pend_q);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_addr = addr_q;
        issue_left = left_q;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    issue_addr = start_addr;
                    issue_left = start_count;
                    if (start_count != '0) begin
                        issue      = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (left_q != '0 && occupancy < (FifoCountW + 1)'(FifoDepth)) begin
                    issue = 1'b1;
                end
                if (left_q == '0 || (issue && left_q == CountWidth'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        issue_last = (issue_left == CountWidth'(1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            ab_q        <= '0;
            reb_q       <= 1'b0;
            reb_last_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state       <= state_next;
            reb_q       <= issue;
            reb_last_q  <= issue_last;
            pend_q      <= reb_q;
            pend_last_q <= reb_last_q;
            if (issue) begin
                ab_q   <= issue_addr;
                addr_q <= (issue_addr == LastRow) ? '0 : issue_addr + AddressWidth'(1);
                left_q <= issue_left - CountWidth'(1);
            end
        end
    end

    // The issue credit guarantees room, so the full guard never drops a row.
    assign fifo_push = pend_q && !fifo_full;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FifoDepth)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .wdata ({pend_last_q, Q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_rdata[WIDTH-1:0];
    assign out_last    = !fifo_empty && fifo_rdata[WIDTH];
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign REB         = reb_q;
    assign AB          = ab_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model, command table, hand sequences and a random phase,
// all checked against a per-command list of expected addresses and beats.
module tb_sram_stream_reader;
    import sram_stream_pkg::*;

    localparam int WIDTH    = 16;
    localparam int NUM_ROWS = 16;
    localparam int AW       = $clog2(NUM_ROWS);
    localparam int CW       = $clog2(NUM_ROWS + 1);
    localparam int DEPTH    = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [AW-1:0]    start_addr = '0;
    logic [CW-1:0]    start_count = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             REB;
    logic [AW-1:0]    AB;
    logic [WIDTH-1:0] Q;
    state_e           dbg_state;

    sram_stream_reader #(
        .WIDTH    (WIDTH),
        .NUM_ROWS (NUM_ROWS)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_addr  (start_addr),
        .start_count (start_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .REB         (REB),
        .AB          (AB),
        .Q           (Q),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / SRAM model ----------------
    always #5 CLK = ~CLK;

    logic [WIDTH-1:0] mem [NUM_ROWS];
    always @(posedge CLK) begin
        if (REB) Q <= mem[AB];
    end

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [WIDTH:0]  exp_q[$];
    logic [AW-1:0]   addr_q[$];
    bit              model_busy = 0;
    bit              wait_first = 0;
    bit              stall_prev = 0;
    logic [WIDTH:0]  stall_val;
    int              cyc = 0;
    int              hs_cyc = 0;
    int              issued = 0;
    int              taken = 0;
    int              cmd_beats = 0;
    logic [WIDTH-1:0] cmd_first;
    logic [WIDTH-1:0] cmd_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: evaluate everything visible before the edge, then advance to the next negedge.
    task automatic tick();
        logic [WIDTH:0] head;
        bit idle;
        int a;
        if (RST) begin
            exp_q.delete();
            addr_q.delete();
            model_busy = 0;
            wait_first = 0;
            stall_prev = 0;
            issued = 0;
            taken = 0;
        end else begin
            idle = !model_busy;
            check("start_ready", start_ready, idle);
            check("busy", busy, !idle);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_last, out_data}, stall_val);
            end
            if (REB) begin
                if (addr_q.size() == 0) check("reb_unexpected", REB, 0);
                else check("ab", AB, addr_q.pop_front());
                issued++;
                check("outstanding_over_depth", (issued - taken) > DEPTH, 0);
            end
            if (out_valid && wait_first) begin
                check("first_latency", cyc - hs_cyc, 3);
                wait_first = 0;
            end
            if (out_valid && exp_q.size() == 0) check("stale_valid", out_valid, 0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                check("beat", {out_last, out_data}, head);
                taken++;
                if (cmd_beats == 0) cmd_first = out_data;
                cmd_last = out_data;
                cmd_beats++;
                if (head[WIDTH]) model_busy = 0;
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_last, out_data};
            if (start_valid && idle) begin
                hs_cyc = cyc;
                if (start_count != 0) begin
                    model_busy = 1;
                    wait_first = 1;
                    for (int i = 0; i < int'(start_count); i++) begin
                        a = (int'(start_addr) + i) % NUM_ROWS;
                        addr_q.push_back(AW'(a));
                        exp_q.push_back({(i == int'(start_count) - 1), mem[a]});
                    end
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input int addr, input int count);
        cmd_beats   = 0;
        start_valid = 1'b1;
        start_addr  = AW'(addr);
        start_count = CW'(count);
        tick();
        start_valid = 1'b0;
        start_addr  = AW'($urandom);
        start_count = CW'($urandom);
    endtask

    // mode 0: always ready; 1: stall 10 cycles after first valid then toggle; 2: random ready
    task automatic wait_idle(input int mode);
        int budget = 0;
        int since_valid = 0;
        bit seen = 0;
        while (model_busy && budget < 400) begin
            if (out_valid) seen = 1;
            if (seen) since_valid++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (since_valid > 10) ? since_valid[0] : 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            tick();
            budget++;
        end
        check("cmd_done", model_busy, 0);
        out_ready = 1'b1;
        tick();
    endtask

    typedef struct {
        int               addr;
        int               count;
        int               mode;
        int               exp_beats;
        logic [WIDTH-1:0] exp_first;
        logic [WIDTH-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NUM_ROWS; i++) mem[i] = WIDTH'(16'h0096 + i);

        // row r holds 0x96 + r, so rows 10..13 hold 0xA0..0xA3
        vecs[0] = '{10, 4,  0, 4,  16'h00A0, 16'h00A3};
        vecs[1] = '{14, 4,  0, 4,  16'h00A4, 16'h0097};
        vecs[2] = '{0,  8,  1, 8,  16'h0096, 16'h009D};
        vecs[3] = '{3,  0,  0, 0,  16'h0000, 16'h0000};
        vecs[4] = '{5,  16, 0, 16, 16'h009B, 16'h009A};
        vecs[5] = '{15, 1,  0, 1,  16'h00A5, 16'h00A5};

        // reset values
        @(negedge CLK);
        RST = 1'b1;
        tick();
        tick();
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_reb", REB, 0);
        check("rst_ab", AB, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_state", dbg_state, IDLE);
        RST = 1'b0;
        tick();

        // table-driven commands
        for (int v = 0; v < 6; v++) begin
            start_cmd(vecs[v].addr, vecs[v].count);
            wait_idle(vecs[v].mode);
            check("vec_beats", cmd_beats, vecs[v].exp_beats);
            if (vecs[v].exp_beats > 0) begin
                check("vec_first", cmd_first, vecs[v].exp_first);
                check("vec_last", cmd_last, vecs[v].exp_last);
            end
        end

        // a second command while busy must be ignored
        start_cmd(2, 5);
        tick();
        tick();
        start_valid = 1'b1;
        start_addr  = AW'(9);
        start_count = CW'(3);
        tick();
        start_valid = 1'b0;
        wait_idle(0);
        check("busy_reject_beats", cmd_beats, 5);

        // reset while a read is in flight
        start_cmd(6, 8);
        for (int k = 0; k < 5 && !REB; k++) tick();
        check("reb_before_reset", REB, 1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_reb", REB, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", start_ready, 1);
        for (int k = 0; k < 6; k++) tick();
        start_cmd(0, 2);
        wait_idle(0);
        check("post_rst_beats", cmd_beats, 2);
        check("post_rst_first", cmd_first, 16'h0096);
        check("post_rst_last", cmd_last, 16'h0097);

        // randomized commands with random backpressure
        for (int r = 0; r < 24; r++) begin
            start_cmd($urandom_range(0, NUM_ROWS - 1), $urandom_range(0, NUM_ROWS));
            wait_idle(2);
        end

        check("exp_q_empty", exp_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
